// File: rtl/sistema_pio_pkg.sv
// Shared constants for the SISTEMA GPIO bank: register map and edge-mode encodings.
package sistema_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Warm-up counter must reach SYNC_STAGES+1 <= 5.
  localparam int unsigned WARM_W = 3;

endpackage

// File: rtl/sistema_pio_sync_edge.sv
// Pin synchroniser, one-cycle-delayed copy and gated edge detector.
module sistema_pio_sync_edge
  import sistema_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic [WARM_W-1:0]                 warm_q, warm_d;
  logic [WIDTH-1:0]                  rise, fall, sel;

  // Next state: shift the chain, delay the synchronised value, saturate warm-up.
  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      warm_q <= warm_d;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Select the configured edge terms; suppressed until the chain has filled.
  always_comb begin
    rise = sync_in & ~prev_q;
    fall = ~sync_in & prev_q;
    if (EDGE_MODE == EDGE_FALL) begin
      sel = fall;
    end else if (EDGE_MODE == EDGE_ANY) begin
      sel = rise | fall;
    end else begin
      sel = rise;
    end
    edge_pulse = (warm_q == WARM_DONE) ? sel : '0;
  end

endmodule

// File: rtl/sistema_pio_gpio.sv
// Bidirectional GPIO bank with Avalon-MM slave, atomic set/clear and edge interrupt.
module sistema_pio_gpio
  import sistema_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 7,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_MODE   = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] sync_in, edge_pulse;
  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             unused_wd;

  sistema_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wd        = writedata[WIDTH-1:0];
  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Write decode; a new edge overrides a same-cycle write-1-to-clear.
  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_d = wd;
        ADDR_DIR:     dir_d  = wd;
        ADDR_IRQMASK: mask_d = wd;
        ADDR_EDGE:    edge_d = edge_q & ~wd;
        ADDR_OUTSET:  data_d = data_q | wd;
        ADDR_OUTCLR:  data_d = data_q & ~wd;
        default:      ;
      endcase
    end
    edge_d = edge_d | edge_pulse;
    irq_d  = |(edge_d & mask_d);
  end

  // Register file with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      irq_q  <= irq_d;
    end
  end

  // Zero-wait-state read mux; unused upper bits and write-only slots read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = BUS_W'((data_q & dir_q) | (sync_in & ~dir_q));
      ADDR_DIR:     readdata = BUS_W'(dir_q);
      ADDR_IRQMASK: readdata = BUS_W'(mask_q);
      ADDR_EDGE:    readdata = BUS_W'(edge_q);
      default:      readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign oe       = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sistema_pio_gpio.sv
// Scoreboard bench for sistema_pio_gpio: three instances covering width and edge-mode corners.
module tb_sistema_pio_gpio;
  import sistema_pio_pkg::*;

  typedef struct {
    int          dut;
    int          sel;   // 0 readdata, 1 out_port, 2 oe, 3 irq
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic [2:0]  cs;
  logic        write_n;
  logic [31:0] writedata;

  logic [6:0]  in0;
  logic [31:0] in1;
  logic [0:0]  in2;
  logic [31:0] rd0, rd1, rd2;
  logic [6:0]  out0, oe0;
  logic [31:0] out1, oe1;
  logic [0:0]  out2, oe2;
  logic        irq0, irq1, irq2;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  sistema_pio_gpio #(.WIDTH(7), .RESET_VALUE(7'h55), .EDGE_MODE(EDGE_RISE), .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in0), .out_port(out0), .oe(oe0), .irq(irq0));

  sistema_pio_gpio #(.WIDTH(32), .RESET_VALUE(32'h0), .EDGE_MODE(EDGE_ANY), .SYNC_STAGES(3)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in1), .out_port(out1), .oe(oe1), .irq(irq1));

  sistema_pio_gpio #(.WIDTH(1), .RESET_VALUE(1'b0), .EDGE_MODE(EDGE_ANY), .SYNC_STAGES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .readdata(rd2), .in_port(in2), .out_port(out2), .oe(oe2), .irq(irq2));

  function automatic logic [31:0] get_obs(int d, int s);
    logic [31:0] r;
    r = '0;
    case (d)
      0: case (s) 0: r = rd0; 1: r = 32'(out0); 2: r = 32'(oe0); default: r = 32'(irq0); endcase
      1: case (s) 0: r = rd1; 1: r = out1;      2: r = oe1;      default: r = 32'(irq1); endcase
      default: case (s) 0: r = rd2; 1: r = 32'(out2); 2: r = 32'(oe2); default: r = 32'(irq2); endcase
    endcase
    return r;
  endfunction

  // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = get_obs(e.dut, e.sel);
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: dut%0d got %h expected %h", e.name, e.dut, act, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input logic [31:0] got, input logic [31:0] v, input string nm);
    n_cmp++;
    if (got !== v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, v);
    end
  endtask

  task automatic expect_v(input int d, input int s, input logic [31:0] v, input string nm);
    exp_t x;
    x.dut = d; x.sel = s; x.exp = v; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
    cs = '0; cs[d] = 1'b1; address = a; write_n = 1'b0; writedata = v;
    tick(1);
    cs = '0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input int d, input logic [2:0] a, input logic [31:0] v, input string nm);
    cs = '0; cs[d] = 1'b1; address = a; write_n = 1'b1;
    expect_v(d, 0, v, nm);
    tick(1);
    cs = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; address = '0; cs = '0; write_n = 1'b1; writedata = '0;
    in0 = 7'h7F; in1 = '0; in2 = '0;
    tick(3);
    expect_v(0, 1, 32'h55, "rst_out_port");
    expect_v(0, 2, 32'h0,  "rst_oe");
    expect_v(0, 3, 32'h0,  "rst_irq");
    expect_v(1, 1, 32'h0,  "rst_out_port_w32");
    chk(32'(out0), 32'h55, "rst_out_port_direct");
    chk(32'(oe0), 32'h0, "rst_oe_direct");
    n_cmp++;
    if (irq0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_irq_direct: got %b expected 0", irq0);
    end
    n_cmp++;
    if (out2 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_port_w1_direct: got %b expected 0", out2);
    end
    tick(1);
    reset_n = 1'b1;
    tick(10);
    rd(0, ADDR_EDGE, 32'h0, "warmup_no_capture");

    // Consecutive DATA / OUTSET / OUTCLR writes
    wr(0, ADDR_DATA, 32'h0F);
    expect_v(0, 1, 32'h0F, "out_after_data");
    wr(0, ADDR_OUTSET, 32'h30);
    expect_v(0, 1, 32'h3F, "out_after_set");
    wr(0, ADDR_OUTCLR, 32'h03);
    expect_v(0, 1, 32'h3C, "out_after_clr");
    chk(32'(out0), 32'h3C, "out_after_clr_direct");
    rd(0, ADDR_OUTSET, 32'h0, "outset_reads_zero");

    // Mixed-direction DATA read; pins fall on several bits (not captured in rise mode)
    in0 = 7'h50;
    wr(0, ADDR_DIR, 32'h0F);
    wr(0, ADDR_DATA, 32'h05);
    tick(3);
    expect_v(0, 2, 32'h0F, "oe_follows_dir");
    expect_v(0, 1, 32'h05, "out_data05");
    rd(0, ADDR_DATA, 32'h55, "data_mixed_read");
    rd(0, ADDR_EDGE, 32'h0, "falls_ignored_rise_mode");

    // Rising edge latency and irq
    wr(0, ADDR_IRQMASK, 32'h01);
    in0[0] = 1'b1;
    expect_v(0, 3, 32'h0, "irq_lat0");
    tick(1);
    expect_v(0, 3, 32'h0, "irq_lat1");
    tick(1);
    expect_v(0, 3, 32'h0, "irq_lat2");
    tick(1);
    expect_v(0, 3, 32'h1, "irq_lat3");
    rd(0, ADDR_EDGE, 32'h01, "edge_bit0_set");
    wr(0, ADDR_EDGE, 32'h01);
    expect_v(0, 3, 32'h0, "irq_cleared");
    rd(0, ADDR_EDGE, 32'h0, "edge_bit0_cleared");
    in0[0] = 1'b0;
    tick(4);
    expect_v(0, 3, 32'h0, "irq_after_fall");
    rd(0, ADDR_EDGE, 32'h0, "fall_not_captured");

    // Edge and write-1-to-clear in the same cycle
    in0[2] = 1'b1;
    tick(2);
    wr(0, ADDR_EDGE, 32'h04);
    rd(0, ADDR_EDGE, 32'h04, "set_beats_clear");
    wr(0, ADDR_EDGE, 32'h04);
    rd(0, ADDR_EDGE, 32'h0, "bit2_cleared");

    // 32-bit any-edge instance, 3-stage synchroniser
    in1 = 32'hA5A5_0001;
    tick(4);
    expect_v(1, 3, 32'h0, "w32_irq_masked");
    rd(1, ADDR_EDGE, 32'hA5A5_0001, "w32_rise");
    wr(1, ADDR_EDGE, 32'hFFFF_FFFF);
    rd(1, ADDR_EDGE, 32'h0, "w32_cleared");
    in1 = 32'h0;
    tick(4);
    rd(1, ADDR_EDGE, 32'hA5A5_0001, "w32_fall");
    wr(1, ADDR_IRQMASK, 32'h8000_0000);
    expect_v(1, 3, 32'h1, "w32_irq");
    rd(1, ADDR_IRQMASK, 32'h8000_0000, "w32_mask_rb");
    wr(1, ADDR_DIR, 32'h1234_5678);
    wr(1, ADDR_DATA, 32'hCAFE_F00D);
    wr(1, 3'd6, 32'hFFFF_FFFF);
    wr(1, 3'd7, 32'hFFFF_FFFF);
    expect_v(1, 1, 32'hCAFE_F00D, "w32_out_after_67");
    expect_v(1, 2, 32'h1234_5678, "w32_oe_after_67");
    chk(out1, 32'hCAFE_F00D, "w32_out_after_67_direct");
    rd(1, ADDR_DIR, 32'h1234_5678, "w32_dir_rb");
    rd(1, ADDR_DATA, 32'h0234_5008, "w32_data_mixed");
    rd(1, 3'd6, 32'h0, "w32_addr6_zero");
    rd(1, 3'd7, 32'h0, "w32_addr7_zero");
    rd(1, ADDR_EDGE, 32'hA5A5_0001, "w32_edge_kept");
    rd(1, ADDR_IRQMASK, 32'h8000_0000, "w32_mask_kept");

    // 1-bit any-edge instance
    in2 = 1'b1;
    tick(3);
    rd(2, ADDR_EDGE, 32'h1, "w1_rise");
    wr(2, ADDR_EDGE, 32'h1);
    rd(2, ADDR_EDGE, 32'h0, "w1_cleared");
    in2 = 1'b0;
    tick(3);
    rd(2, ADDR_EDGE, 32'h1, "w1_fall");
    wr(2, ADDR_IRQMASK, 32'hFFFF_FFFF);
    expect_v(2, 3, 32'h1, "w1_irq");
    rd(2, ADDR_IRQMASK, 32'h1, "w1_mask_upper_zero");
    wr(2, 3'd6, 32'hFFFF_FFFF);
    wr(2, 3'd7, 32'hFFFF_FFFF);
    expect_v(2, 1, 32'h0, "w1_out_after_67");
    rd(2, ADDR_DIR, 32'h0, "w1_dir_after_67");
    rd(2, ADDR_DATA, 32'h0, "w1_data_after_67");

    // Reset while a capture is pending on u0 (bit0 unmasked)
    in0[0] = 1'b1;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    expect_v(0, 1, 32'h55, "midrst_out_port");
    expect_v(0, 2, 32'h0,  "midrst_oe");
    expect_v(0, 3, 32'h0,  "midrst_irq");
    expect_v(1, 3, 32'h0,  "midrst_irq_w32");
    tick(1);
    reset_n = 1'b1;
    tick(6);
    rd(0, ADDR_EDGE, 32'h0, "midrst_edge_discarded");
    rd(0, ADDR_IRQMASK, 32'h0, "midrst_mask_zero");

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sistema_pio_gpio.md
# sistema_pio_gpio

Parametrised bidirectional PIO with zero-wait-state Avalon-MM slave, per-bit direction control, atomic bit set/clear, synchronised input sampling, edge capture and a level interrupt. Next-generation replacement for the fixed 7-bit output-only PIO in the SISTEMA Qsys system: drives LEDs/actuator enables and reads MYO-board status lines through one peripheral. One instance per GPIO bank; `irq` connects to the Nios II interrupt controller.

## Interface
Parameters:
- `WIDTH`, 7: number of GPIO bits, legal range 1..32.
- `RESET_VALUE`, 0: reset value of the output data register, `WIDTH` bits.
- `EDGE_MODE`, 0: capture condition. 0 = rising, 1 = falling, 2 = any edge.
- `SYNC_STAGES`, 2: input synchroniser depth, legal range 2..4.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: reset, synchronous, active-low, sampled on `clk` rising edge.
- `address` in 3: register word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 32: write data; only bits `[WIDTH-1:0]` are used.
- `readdata` out 32: read data, combinational from `address`; bits above `WIDTH` are 0.
- `in_port` in WIDTH: asynchronous pin inputs.
- `out_port` out WIDTH: output data register.
- `oe` out WIDTH: per-bit output enable, equal to the direction register (1 = output).
- `irq` out 1: level interrupt, `|(edge_capture & irq_mask)`.

## Operation
Register map. A write occurs when `chipselect` = 1 and `write_n` = 0.
- 0 DATA: write loads `data_out`. Read returns `(data_out & dir) | (sync_in & ~dir)`.
- 1 DIR: read/write direction register.
- 2 IRQMASK: read/write interrupt mask.
- 3 EDGE: read returns `edge_capture`. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 4 OUTSET: write performs `data_out |= wd`. Reads 0.
- 5 OUTCLR: write performs `data_out &= ~wd`. Reads 0.
- 6, 7: writes ignored, reads 0.

Input path and edge capture:
- `in_port` passes through `SYNC_STAGES` flops to give `sync_in`, then one more flop to give `sync_prev`.
- Edge terms: rise = `sync_in & ~sync_prev`; fall = `~sync_in & sync_prev`.
- The edge bits selected by `EDGE_MODE` set `edge_capture` bits.
- Edge capture is detected on all bits regardless of DIR, so output pins can loop back.

Warm-up:
- A counter runs from 0 to `SYNC_STAGES+1` after reset.
- Edge detection is gated off until the counter saturates, so pins that are static at reset produce no spurious captures.

## Timing
Reset (`reset_n` low at a `clk` edge):
- `data_out` = `RESET_VALUE`.
- `dir`, `irq_mask`, `edge_capture`, synchroniser flops, `sync_prev` and the warm-up counter = 0.
- Outputs: `out_port` = `RESET_VALUE`, `oe` = 0, `irq` = 0.
- `readdata` follows `address` combinationally.
- Reset asserted mid-operation discards pending captures in the same cycle.

Write latency:
- A register write takes effect at the `clk` edge that samples it.
- `out_port`, `oe` and `irq` update in the following cycle, i.e. one cycle after the write.

Read latency:
- 0 cycles. A read in the cycle after a write returns the new value.

Input latency:
- A pin change stable before clock edge k appears in `sync_in` after edge k+`SYNC_STAGES`-1.
- The matching `edge_capture` bit and `irq` are set after edge k+`SYNC_STAGES`.

Simultaneous events:
- A new edge and a write-1-to-clear on the same bit in the same cycle: the set wins, so the bit stays 1.
- OUTSET/OUTCLR are read-modify-write in a single cycle, so consecutive-cycle set/clear writes are never lost.

## Structure
- Package `sistema_pio_pkg` holds:
  - address constants `ADDR_DATA`, `ADDR_DIR`, `ADDR_IRQMASK`, `ADDR_EDGE`, `ADDR_OUTSET`, `ADDR_OUTCLR`;
  - `EDGE_MODE` encodings `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- Sub-module `sistema_pio_sync_edge`, parametrised by `WIDTH`, `SYNC_STAGES` and `EDGE_MODE`, contains:
  - the synchroniser chain, `sync_prev` and the warm-up counter;
  - outputs `sync_in` and the per-bit one-cycle `edge_pulse`.
- The top level holds the register file, the write decode, the read mux and the irq logic.

## Test plan
- Reset with `RESET_VALUE`=7'h55 and `in_port`=7'h7F held high:
  - `out_port`=7'h55, `oe`=0 and `irq`=0 after reset;
  - EDGE reads 0 after 10 cycles (warm-up suppresses captures).
- Write DATA=7'h0F, then OUTSET=7'h30, then OUTCLR=7'h03 on consecutive cycles:
  - `out_port` sequence is 7'h0F, 7'h3F, 7'h3C;
  - a read of address 4 returns 0.
- DIR=7'h0F, DATA=7'h05, `in_port`=7'h50:
  - DATA reads 7'h55;
  - `readdata[31:7]`=0.
- `EDGE_MODE`=0, IRQMASK=7'h01, rising edge on `in_port[0]`:
  - `edge_capture[0]` and `irq` assert exactly `SYNC_STAGES`+1 cycles after the pin change;
  - a falling edge does not set the bit;
  - writing EDGE=7'h01 clears the bit and deasserts `irq` the next cycle.
- A new edge on bit 2 lands in the same cycle as an EDGE write of 7'h04:
  - bit 2 stays 1.
- `EDGE_MODE`=2 with `WIDTH`=32 and `WIDTH`=1:
  - both edge directions are captured;
  - writes to addresses 6 and 7 change no register.
